// File: rtl/obj_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : obj_scheduler
//  Purpose  : Per-frame sequencer for the five sprite slots: scroll, animate,
//             retire, then service one spawn request via req/ack/drop.
//  Options  : OBJ_SCHED_WRAP_EN - wrap off-screen objects to WRAP_HPOS
//             instead of retiring them.
//  Revision : 1.0 - initial release
// ============================================================================
module obj_scheduler #(
  parameter int SPAWN_HPOS   = 1023,
  parameter int ANIM_DIV_LOG = 3
`ifdef OBJ_SCHED_WRAP_EN
  , parameter int WRAP_HPOS  = 1023
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic [3:0]  speed,
  input  logic        spawn_req,
  input  logic [1:0]  spawn_type,
  input  logic [9:0]  spawn_vpos,
  output logic        spawn_ack,
  output logic        spawn_drop,
  output logic [25:0] obj1,
  output logic [25:0] obj2,
  output logic [25:0] obj3,
  output logic [25:0] obj4,
  output logic [25:0] obj5,
  output logic [4:0]  active_mask,
  output logic [7:0]  frame_count,
  output logic        busy
);

  localparam logic [1:0]  C_IDLE       = 2'd0;
  localparam logic [1:0]  C_UPD        = 2'd1;
  localparam logic [1:0]  C_SPAWN      = 2'd2;
  localparam logic [10:0] C_SPAWN_HPOS = 11'(SPAWN_HPOS);
`ifdef OBJ_SCHED_WRAP_EN
  localparam logic [10:0] C_WRAP_HPOS  = 11'(WRAP_HPOS);
`endif

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic        r_vsync_d;
  logic        r_anim_tick;
  logic [7:0]  r_frame_count;
  logic        r_spawn_ack;
  logic        r_spawn_drop;
  logic [25:0] r_obj [5];

  logic        w_frame_event;
  logic [25:0] w_cur;
  logic [25:0] w_upd;
  logic [2:0]  w_anim;
  logic [1:0]  w_type;
  logic [10:0] w_hpos;
  logic [10:0] w_speed;
  logic        w_free_found;
  logic [2:0]  w_free_idx;

  assign w_frame_event = r_vsync_d & ~vsync;

  // Slot currently addressed by the UPD walk and its next value.
  always_comb begin
    w_cur = 26'd0;
    for (int i = 0; i < 5; i++) begin
      if (r_idx == 3'(i)) w_cur = r_obj[i];
    end
    w_anim  = w_cur[25:23] + {2'b00, r_anim_tick};
    w_type  = w_cur[22:21];
    w_hpos  = w_cur[20:10];
    w_speed = {7'd0, speed};
    w_upd   = w_cur;
    if (w_type != 2'd0) begin
      if (w_hpos < w_speed) begin
`ifdef OBJ_SCHED_WRAP_EN
        w_upd = {w_anim, w_type, C_WRAP_HPOS, w_cur[9:0]};
`else
        w_upd = 26'd0;
`endif
      end else begin
        w_upd = {w_anim, w_type, w_hpos - w_speed, w_cur[9:0]};
      end
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (r_obj[i][22:21] == 2'd0) begin
        w_free_found = 1'b1;
        w_free_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= C_IDLE;
      r_idx         <= 3'd0;
      r_vsync_d     <= 1'b0;
      r_anim_tick   <= 1'b0;
      r_frame_count <= 8'd0;
      r_spawn_ack   <= 1'b0;
      r_spawn_drop  <= 1'b0;
      for (int i = 0; i < 5; i++) r_obj[i] <= 26'd0;
    end else begin
      r_vsync_d    <= vsync;
      r_spawn_ack  <= 1'b0;
      r_spawn_drop <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (w_frame_event) begin
            r_state       <= C_UPD;
            r_idx         <= 3'd0;
            r_anim_tick   <= (r_frame_count[ANIM_DIV_LOG-1:0] == '0);
            r_frame_count <= r_frame_count + 8'd1;
          end
        end
        C_UPD: begin
          for (int i = 0; i < 5; i++) begin
            if (r_idx == 3'(i)) r_obj[i] <= w_upd;
          end
          if (r_idx == 3'd4) begin
            r_state <= C_SPAWN;
            r_idx   <= 3'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        C_SPAWN: begin
          r_state <= C_IDLE;
          if (spawn_req && (spawn_type != 2'd0)) begin
            if (w_free_found) begin
              for (int i = 0; i < 5; i++) begin
                if (w_free_idx == 3'(i))
                  r_obj[i] <= {3'd0, spawn_type, C_SPAWN_HPOS, spawn_vpos};
              end
              r_spawn_ack <= 1'b1;
            end else begin
              r_spawn_drop <= 1'b1;
            end
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) active_mask[i] = (r_obj[i][22:21] != 2'd0);
  end

  assign obj1        = r_obj[0];
  assign obj2        = r_obj[1];
  assign obj3        = r_obj[2];
  assign obj4        = r_obj[3];
  assign obj5        = r_obj[4];
  assign frame_count = r_frame_count;
  assign spawn_ack   = r_spawn_ack;
  assign spawn_drop  = r_spawn_drop;
  assign busy        = (r_state != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_obj_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obj_scheduler
//  Purpose  : Scoreboard bench for obj_scheduler (spawn, scroll/retire,
//             animation, full slots, busy overlap, reset mid-sequence).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obj_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        vsync;
  logic [3:0]  speed;
  logic        spawn_req;
  logic [1:0]  spawn_type;
  logic [9:0]  spawn_vpos;
  logic        spawn_ack;
  logic        spawn_drop;
  logic [25:0] obj1, obj2, obj3, obj4, obj5;
  logic [4:0]  active_mask;
  logic [7:0]  frame_count;
  logic        busy;

  always #5 clock = ~clock;

  obj_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .speed       (speed),
    .spawn_req   (spawn_req),
    .spawn_type  (spawn_type),
    .spawn_vpos  (spawn_vpos),
    .spawn_ack   (spawn_ack),
    .spawn_drop  (spawn_drop),
    .obj1        (obj1),
    .obj2        (obj2),
    .obj3        (obj3),
    .obj4        (obj4),
    .obj5        (obj5),
    .active_mask (active_mask),
    .frame_count (frame_count),
    .busy        (busy)
  );

  typedef struct packed {
    logic [4:0][25:0] o;
    logic [4:0]       mask;
    logic [7:0]       fc;
    logic             ack;
    logic             drop;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  int   m_anim[5], m_type[5], m_hpos[5], m_vpos[5];
  int   m_fc;

  logic [4:0][25:0] act_o;
  assign act_o = {obj5, obj4, obj3, obj2, obj1};

  function automatic logic [25:0] pack(input int a, input int t, input int h, input int v);
    return {3'(a), 2'(t), 11'(h), 10'(v)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_anim[i] = 0; m_type[i] = 0; m_hpos[i] = 0; m_vpos[i] = 0;
    end
    m_fc = 0;
  endtask

  // Reference behaviour of one frame; pushes the expected post-frame view.
  task automatic model_frame(input int spd, input bit req, input int typ, input int vp);
    exp_t e;
    int   tick;
    int   slot;
    tick = ((m_fc % 8) == 0) ? 1 : 0;
    m_fc = (m_fc + 1) % 256;
    for (int i = 0; i < 5; i++) begin
      if (m_type[i] != 0) begin
        m_anim[i] = (m_anim[i] + tick) % 8;
        if (m_hpos[i] < spd) begin
`ifdef OBJ_SCHED_WRAP_EN
          m_hpos[i] = 1023;
`else
          m_anim[i] = 0; m_type[i] = 0; m_hpos[i] = 0; m_vpos[i] = 0;
`endif
        end else begin
          m_hpos[i] = m_hpos[i] - spd;
        end
      end
    end
    e.ack  = 1'b0;
    e.drop = 1'b0;
    if (req && typ != 0) begin
      slot = -1;
      for (int i = 4; i >= 0; i--) if (m_type[i] == 0) slot = i;
      if (slot >= 0) begin
        m_anim[slot] = 0; m_type[slot] = typ; m_hpos[slot] = 1023; m_vpos[slot] = vp;
        e.ack = 1'b1;
      end else begin
        e.drop = 1'b1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      e.o[i]    = pack(m_anim[i], m_type[i], m_hpos[i], m_vpos[i]);
      e.mask[i] = (m_type[i] != 0);
    end
    e.fc = 8'(m_fc);
    sb.push_back(e);
  endtask

  // Monitor: a falling busy edge (outside reset) marks a completed frame.
  logic busy_prev = 1'b0;
  bit   rst_recent = 1'b1;
  always @(negedge clock) begin : mon
    bit   fell;
    exp_t e;
    fell = busy_prev && !busy;
    if (fell && !rst_recent) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) chk($sformatf("obj%0d", i + 1), 32'(act_o[i]), 32'(e.o[i]));
        chk("active_mask", 32'(active_mask), 32'(e.mask));
        chk("frame_count", 32'(frame_count), 32'(e.fc));
        chk("spawn_ack", 32'(spawn_ack), 32'(e.ack));
        chk("spawn_drop", 32'(spawn_drop), 32'(e.drop));
      end
      frames_done++;
    end else begin
      chk("stray_pulse", {30'd0, spawn_ack, spawn_drop}, 32'd0);
    end
    busy_prev  = busy;
    rst_recent = reset;
  end

  task automatic vsync_fall();
    @(posedge clock); #1 vsync = 1'b1;
    @(posedge clock); #1 vsync = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < 30) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("frame_timeout", (frames_done >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_frame(input int spd, input bit req, input int typ, input int vp);
    int tgt;
    speed = 4'(spd); spawn_req = req; spawn_type = 2'(typ); spawn_vpos = 10'(vp);
    model_frame(spd, req, typ, vp);
    tgt = frames_done + 1;
    vsync_fall();
    wait_done(tgt);
  endtask

  task automatic check_zero_state();
    chk("rst_obj1", 32'(obj1), 32'd0);
    chk("rst_obj2", 32'(obj2), 32'd0);
    chk("rst_obj3", 32'(obj3), 32'd0);
    chk("rst_obj4", 32'(obj4), 32'd0);
    chk("rst_obj5", 32'(obj5), 32'd0);
    chk("rst_mask", 32'(active_mask), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack_drop", {30'd0, spawn_ack, spawn_drop}, 32'd0);
  endtask

  // Reset lands two slots into the UPD walk.
  task automatic reset_mid_upd();
    vsync_fall();
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    model_reset();
    @(negedge clock);
    check_zero_state();
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; speed = 4'd0;
    spawn_req = 1'b0; spawn_type = 2'd0; spawn_vpos = 10'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_zero_state();
    @(posedge clock); #1;

    // Spawn into empty table, then one scroll step.
    run_frame(4, 1'b1, 2, 300);
    chk("spawn_obj1", 32'(obj1), 32'(pack(0, 2, 1023, 300)));
    chk("spawn_mask", 32'(active_mask), 32'd1);
    run_frame(4, 1'b0, 0, 0);
    chk("scroll_1019", 32'(obj1[20:10]), 32'd1019);

    // Scroll down to hpos 8, then 4, 0 (still active), then off-screen.
    for (int k = 0; k < 67; k++) run_frame(15, 1'b0, 0, 0);
    run_frame(6, 1'b0, 0, 0);
    chk("hpos_8", 32'(obj1[20:10]), 32'd8);
    run_frame(4, 1'b0, 0, 0);
    chk("hpos_4", 32'(obj1[20:10]), 32'd4);
    run_frame(4, 1'b0, 0, 0);
    chk("hpos_0", 32'(obj1[20:10]), 32'd0);
    chk("hpos_0_active", 32'(active_mask), 32'd1);
    run_frame(4, 1'b0, 0, 0);
`ifdef OBJ_SCHED_WRAP_EN
    chk("wrap_hpos", 32'(obj1[20:10]), 32'd1023);
    chk("wrap_mask", 32'(active_mask), 32'd1);
`else
    chk("retire_obj1", 32'(obj1), 32'd0);
    chk("retire_mask", 32'(active_mask), 32'd0);
`endif

    reset_mid_upd();

    // Held request fills all five slots, sixth frame must drop.
    for (int k = 0; k < 6; k++) run_frame(1, 1'b1, 3, 50);
    spawn_req = 1'b0;
    chk("full_mask", 32'(active_mask), 32'h1f);
    chk("full_obj1", 32'(obj1), 32'(pack(0, 3, 1018, 50)));
    chk("full_obj5", 32'(obj5), 32'(pack(0, 3, 1022, 50)));

    // Second falling vsync three cycles into the sequence is ignored.
    begin
      int tgt;
      speed = 4'd1;
      model_frame(1, 1'b0, 0, 0);
      tgt = frames_done + 1;
      vsync_fall();
      @(posedge clock);
      @(posedge clock); #1 vsync = 1'b1;
      @(posedge clock); #1 vsync = 1'b0;
      wait_done(tgt);
      repeat (12) @(posedge clock);
      #1;
      chk("overlap_fc", 32'(frame_count), 32'd7);
    end

    reset_mid_upd();

    // Animation cadence across the 255->0 frame_count wrap.
    run_frame(0, 1'b1, 1, 100);
    spawn_req = 1'b0;
    for (int k = 0; k < 255; k++) run_frame(0, 1'b0, 0, 0);
    chk("anim_fc_wrap", 32'(frame_count), 32'd0);
    chk("anim_7", 32'(obj1[25:23]), 32'd7);
    for (int k = 0; k < 16; k++) run_frame(0, 1'b0, 0, 0);
    chk("anim_end", 32'(obj1[25:23]), 32'd1);
    chk("anim_fc16", 32'(frame_count), 32'd16);
    chk("anim_hpos", 32'(obj1[20:10]), 32'd1023);

    repeat (5) @(posedge clock);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
